// File: rtl/median_send_arbiter_if.sv
// Bus bundle between the two partition buffers, the arbiter and the shared
// output FIFOs. The master modport is the arbiter's view; the slave modport is
// the view of the buffers, the FIFOs and any status observer.
interface median_send_arbiter_if #(
    parameter int BUFF_SIZE_BIT = 6,
    parameter int DATA_WIDTH    = 8
);
    // requester 0 (lower partition buffer)
    logic                     req0;
    logic [BUFF_SIZE_BIT-1:0] size0;
    logic [DATA_WIDTH-1:0]    px0;
    logic                     rd0;

    // requester 1 (upper partition buffer)
    logic                     req1;
    logic [BUFF_SIZE_BIT-1:0] size1;
    logic [DATA_WIDTH-1:0]    px1;
    logic                     rd1;

    // shared pixel FIFO
    logic [DATA_WIDTH-1:0]    out_px;
    logic                     out_px_wr;
    logic                     out_px_full;

    // shared header FIFO
    logic [BUFF_SIZE_BIT-1:0] out_size;
    logic                     out_src;
    logic                     out_hdr_wr;
    logic                     out_hdr_full;

    // status
    logic                     busy;
    logic                     grant;
    logic [BUFF_SIZE_BIT-1:0] count;

    modport master (
        input  req0, size0, px0,
        input  req1, size1, px1,
        input  out_px_full, out_hdr_full,
        output rd0, rd1,
        output out_px, out_px_wr,
        output out_size, out_src, out_hdr_wr,
        output busy, grant, count
    );

    modport slave (
        output req0, size0, px0,
        output req1, size1, px1,
        output out_px_full, out_hdr_full,
        input  rd0, rd1,
        input  out_px, out_px_wr,
        input  out_size, out_src, out_hdr_wr,
        input  busy, grant, count
    );
endinterface

// File: rtl/median_send_arbiter.sv
// Round-robin burst scheduler for the two median-filter partition buffers.
// One requester is granted at a time; its burst size is sampled (clamped to
// BUFF_SIZE), a single header word is written, then exactly that many pixels
// are streamed from the granted buffer into the shared pixel FIFO, popping the
// buffer once per accepted pixel. The FIFOs' full flags stall the transfer.
module median_send_arbiter #(
    parameter int BUFF_SIZE     = 32,
    parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    median_send_arbiter_if.master bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    localparam logic [BUFF_SIZE_BIT-1:0] MAX_SIZE = BUFF_SIZE_BIT'(BUFF_SIZE);
    localparam logic [BUFF_SIZE_BIT-1:0] ONE      = BUFF_SIZE_BIT'(1);
    localparam logic [BUFF_SIZE_BIT-1:0] ZERO     = '0;

    logic [1:0]               state;
    logic [1:0]               state_next;

    // requester that finished most recently; the other side wins a tie
    logic                     last;
    logic                     grant_r;
    logic [BUFF_SIZE_BIT-1:0] size_samp;
    logic [BUFF_SIZE_BIT-1:0] count_r;

    logic                     win_valid;
    logic                     winner;
    logic [BUFF_SIZE_BIT-1:0] win_size_raw;
    logic [BUFF_SIZE_BIT-1:0] win_size;

    logic                     hdr_fire;
    logic                     px_fire;
    logic                     burst_end;
    logic [DATA_WIDTH-1:0]    px_sel;

    // Pick the winner among the active requests and clamp its burst size.
    always_comb begin
        win_valid = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            winner = ~last;
        end else begin
            winner = bus.req1;
        end
        win_size_raw = winner ? bus.size1 : bus.size0;
        win_size     = (win_size_raw > MAX_SIZE) ? MAX_SIZE : win_size_raw;
    end

    // Header and pixel write enables; a pixel write at count == size-1 closes the burst.
    always_comb begin
        hdr_fire  = (state == HDR)  && !bus.out_hdr_full;
        px_fire   = (state == SEND) && !bus.out_px_full;
        burst_end = px_fire && (count_r == (size_samp - ONE));
    end

    // Head pixel of whichever buffer currently owns the output path.
    always_comb begin
        px_sel = grant_r ? bus.px1 : bus.px0;
    end

    // Next-state logic: IDLE -> HDR on a win, HDR -> SEND (or back to IDLE for
    // an empty burst) once the header is accepted, SEND -> IDLE on the last pixel.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (hdr_fire) begin
                    state_next = (size_samp == ZERO) ? IDLE : SEND;
                end
            end
            SEND: begin
                if (burst_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset aborts any burst immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant and burst-size capture, taken only while arbitrating in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r   <= 1'b0;
            size_samp <= ZERO;
        end else if ((state == IDLE) && win_valid) begin
            grant_r   <= winner;
            size_samp <= win_size;
        end
    end

    // Round-robin history, updated when a burst (empty or not) completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (hdr_fire && (size_samp == ZERO)) begin
            last <= grant_r;
        end else if (burst_end) begin
            last <= grant_r;
        end
    end

    // Pixel counter: advances per accepted pixel, holds under backpressure, clears at burst end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= ZERO;
        end else if (burst_end) begin
            count_r <= ZERO;
        end else if (px_fire) begin
            count_r <= count_r + ONE;
        end
    end

    assign bus.out_hdr_wr = hdr_fire;
    assign bus.out_size   = size_samp;
    assign bus.out_src    = grant_r;

    assign bus.out_px_wr  = px_fire;
    assign bus.out_px     = px_sel;
    assign bus.rd0        = px_fire & ~grant_r;
    assign bus.rd1        = px_fire &  grant_r;

    assign bus.busy       = (state != IDLE);
    assign bus.grant      = grant_r;
    assign bus.count      = count_r;

endmodule

// File: tb/tb_median_send_arbiter.sv
// Directed bench for median_send_arbiter. Each buffer is modelled as a
// first-word-fall-through source whose head pixel is base + pops-so-far
// (10 + n for buffer 0, 100 + n for buffer 1); reset clears the pop counts.
module tb_median_send_arbiter;

    localparam int BSB = 6;
    localparam int DW  = 8;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   idx0;
    int   idx1;

    median_send_arbiter_if #(.BUFF_SIZE_BIT(BSB), .DATA_WIDTH(DW)) bus ();

    median_send_arbiter #(
        .BUFF_SIZE     (32),
        .BUFF_SIZE_BIT (BSB),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Buffer pop counters, advanced on every rd strobe seen at a clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            idx0 <= 0;
            idx1 <= 0;
        end else begin
            if (bus.rd0) idx0 <= idx0 + 1;
            if (bus.rd1) idx1 <= idx1 + 1;
        end
    end

    assign bus.px0 = 8'(10 + idx0);
    assign bus.px1 = 8'(100 + idx1);

    task automatic do_reset();
        rst              = 1'b1;
        bus.req0         = 1'b0;
        bus.req1         = 1'b0;
        bus.size0        = '0;
        bus.size1        = '0;
        bus.out_px_full  = 1'b0;
        bus.out_hdr_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        #1;
        tests++;
        if ({bus.busy, bus.out_hdr_wr, bus.out_px_wr, bus.rd0, bus.rd1} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL reset_strobes got=%b want=00000",
                     {bus.busy, bus.out_hdr_wr, bus.out_px_wr, bus.rd0, bus.rd1});
        end
        tests++;
        if ({bus.grant, bus.count, bus.out_size, bus.out_src} !== 14'd0) begin
            fails++;
            $display("[TB] FAIL reset_regs grant=%b count=%0d out_size=%0d out_src=%b want all 0",
                     bus.grant, bus.count, bus.out_size, bus.out_src);
        end
        bus.req0  = 1'b1;
        bus.size0 = 6'd8;
        n = 0;
        while (!(bus.out_px_wr && bus.count == 6'd5) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (n >= 30) begin
            fails++;
            $display("[TB] FAIL reset_wait_count5 got=timeout want=count 5 within 30 cycles");
        end
        tests++;
        if (bus.rd0 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_pre_rd0 got=%b want=1", bus.rd0);
        end
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.out_px_wr, bus.rd0, bus.rd1, bus.out_hdr_wr, bus.busy} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL reset_midburst_strobes got=%b want=00000",
                     {bus.out_px_wr, bus.rd0, bus.rd1, bus.out_hdr_wr, bus.busy});
        end
        tests++;
        if (bus.count !== 6'd0) begin
            fails++;
            $display("[TB] FAIL reset_midburst_count got=%0d want=0", bus.count);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.req0  = 1'b1;
        bus.size0 = 6'd1;
        bus.req1  = 1'b1;
        bus.size1 = 6'd1;
        @(posedge clk);
        #1;
        tests++;
        if ({bus.busy, bus.out_hdr_wr, bus.grant, bus.out_src} !== 4'b1100) begin
            fails++;
            $display("[TB] FAIL reset_first_tie busy,hdr_wr,grant,src got=%b want=1100",
                     {bus.busy, bus.out_hdr_wr, bus.grant, bus.out_src});
        end
    endtask

    task automatic test_single_burst();
        bit   [6:0] eb = 7'b0111110;
        bit   [6:0] eh = 7'b0000010;
        bit   [6:0] ep = 7'b0111100;
        logic [5:0] ec [7] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd0};
        logic [7:0] e0 = 8'd10;
        do_reset();
        bus.req0  = 1'b1;
        bus.size0 = 6'd4;
        for (int c = 0; c < 7; c++) begin
            #1;
            tests++;
            if ({bus.busy, bus.out_hdr_wr, bus.out_px_wr, bus.rd0, bus.rd1} !==
                {eb[c], eh[c], ep[c], ep[c], 1'b0}) begin
                fails++;
                $display("[TB] FAIL single_strobes c=%0d got=%b want=%b", c,
                         {bus.busy, bus.out_hdr_wr, bus.out_px_wr, bus.rd0, bus.rd1},
                         {eb[c], eh[c], ep[c], ep[c], 1'b0});
            end
            tests++;
            if (bus.count !== ec[c]) begin
                fails++;
                $display("[TB] FAIL single_count c=%0d got=%0d want=%0d", c, bus.count, ec[c]);
            end
            if (eh[c]) begin
                tests++;
                if ({bus.out_size, bus.out_src} !== {6'd4, 1'b0}) begin
                    fails++;
                    $display("[TB] FAIL single_header got=%0d/%b want=4/0", bus.out_size, bus.out_src);
                end
            end
            if (ep[c]) begin
                tests++;
                if (bus.out_px !== e0) begin
                    fails++;
                    $display("[TB] FAIL single_pixel c=%0d got=%0d want=%0d", c, bus.out_px, e0);
                end
                e0 = e0 + 8'd1;
            end
            @(posedge clk);
            #1;
            if (c == 0) bus.req0 = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int         hdr_cyc [4] = '{1, 5, 10, 14};
        int         hdrs = 0;
        int         pix  = 0;
        logic       src;
        logic [5:0] prev_size = 6'd0;
        logic [5:0] want_size;
        logic [7:0] e0 = 8'd10;
        logic [7:0] e1 = 8'd100;
        do_reset();
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.size0 = 6'd2;
        bus.size1 = 6'd3;
        for (int c = 0; c < 19; c++) begin
            #1;
            if (bus.out_hdr_wr) begin
                src       = hdrs[0];
                want_size = src ? 6'd3 : 6'd2;
                tests++;
                if (hdrs >= 4 || c != hdr_cyc[hdrs & 3] || bus.out_src !== src ||
                    bus.out_size !== want_size) begin
                    fails++;
                    $display("[TB] FAIL rr_header n=%0d c=%0d got=%0d/%b want=c%0d %0d/%b",
                             hdrs, c, bus.out_size, bus.out_src, hdr_cyc[hdrs & 3], want_size, src);
                end
                if (hdrs > 0) begin
                    tests++;
                    if (pix != int'(prev_size)) begin
                        fails++;
                        $display("[TB] FAIL rr_burst_len n=%0d got=%0d want=%0d", hdrs - 1, pix, prev_size);
                    end
                end
                prev_size = want_size;
                pix       = 0;
                hdrs++;
                if (hdrs == 4) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
            if (bus.out_px_wr) begin
                src = hdrs[0] ^ 1'b1;
                tests++;
                if ({bus.rd1, bus.rd0} !== (src ? 2'b10 : 2'b01) ||
                    bus.out_px !== (src ? e1 : e0)) begin
                    fails++;
                    $display("[TB] FAIL rr_pixel c=%0d rd1,rd0=%b px=%0d want src=%b px=%0d",
                             c, {bus.rd1, bus.rd0}, bus.out_px, src, src ? e1 : e0);
                end
                if (src) e1 = e1 + 8'd1;
                else     e0 = e0 + 8'd1;
                pix++;
            end
            @(posedge clk);
            #1;
        end
        #1;
        tests++;
        if (hdrs != 4 || pix != 3 || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rr_end headers=%0d last_len=%0d busy=%b want 4/3/0", hdrs, pix, bus.busy);
        end
    endtask

    task automatic test_backpressure();
        bit   [8:0] hf = 9'b000000010;
        bit   [8:0] pf = 9'b000110000;
        bit   [8:0] eh = 9'b000000100;
        bit   [8:0] ep = 9'b011001000;
        bit   [8:0] eb = 9'b011111110;
        logic [5:0] ec [9] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1, 6'd2, 6'd0};
        logic [7:0] e1 = 8'd100;
        do_reset();
        bus.req1  = 1'b1;
        bus.size1 = 6'd3;
        for (int c = 0; c < 9; c++) begin
            bus.out_hdr_full = hf[c];
            bus.out_px_full  = pf[c];
            #1;
            tests++;
            if ({bus.busy, bus.out_hdr_wr, bus.out_px_wr, bus.rd1, bus.rd0} !==
                {eb[c], eh[c], ep[c], ep[c], 1'b0}) begin
                fails++;
                $display("[TB] FAIL bp_strobes c=%0d got=%b want=%b", c,
                         {bus.busy, bus.out_hdr_wr, bus.out_px_wr, bus.rd1, bus.rd0},
                         {eb[c], eh[c], ep[c], ep[c], 1'b0});
            end
            tests++;
            if (bus.count !== ec[c]) begin
                fails++;
                $display("[TB] FAIL bp_count c=%0d got=%0d want=%0d", c, bus.count, ec[c]);
            end
            if (eh[c]) begin
                tests++;
                if ({bus.out_size, bus.out_src} !== {6'd3, 1'b1}) begin
                    fails++;
                    $display("[TB] FAIL bp_header got=%0d/%b want=3/1", bus.out_size, bus.out_src);
                end
            end
            if (ep[c]) begin
                tests++;
                if (bus.out_px !== e1) begin
                    fails++;
                    $display("[TB] FAIL bp_pixel c=%0d got=%0d want=%0d", c, bus.out_px, e1);
                end
                e1 = e1 + 8'd1;
            end
            @(posedge clk);
            #1;
            if (c == 0) bus.req1 = 1'b0;
        end
        bus.out_hdr_full = 1'b0;
        bus.out_px_full  = 1'b0;
    endtask

    task automatic test_final_beat_full();
        bit [4:0] pf = 5'b00100;
        bit [4:0] eh = 5'b00010;
        bit [4:0] ep = 5'b01000;
        bit [4:0] eb = 5'b01110;
        do_reset();
        bus.req0  = 1'b1;
        bus.size0 = 6'd1;
        for (int c = 0; c < 5; c++) begin
            bus.out_px_full = pf[c];
            #1;
            tests++;
            if ({bus.busy, bus.out_hdr_wr, bus.out_px_wr, bus.rd0} !== {eb[c], eh[c], ep[c], ep[c]}) begin
                fails++;
                $display("[TB] FAIL lastbeat_strobes c=%0d got=%b want=%b", c,
                         {bus.busy, bus.out_hdr_wr, bus.out_px_wr, bus.rd0},
                         {eb[c], eh[c], ep[c], ep[c]});
            end
            if (ep[c]) begin
                tests++;
                if (bus.out_px !== 8'd10) begin
                    fails++;
                    $display("[TB] FAIL lastbeat_pixel got=%0d want=10", bus.out_px);
                end
            end
            @(posedge clk);
            #1;
            if (c == 0) bus.req0 = 1'b0;
        end
        bus.out_px_full = 1'b0;
    endtask

    task automatic test_zero_size();
        do_reset();
        bus.req0  = 1'b1;
        bus.size0 = 6'd0;
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.out_hdr_wr, bus.out_size, bus.out_src, bus.out_px_wr, bus.rd0} !==
            {1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL zero_header busy=%b hdr_wr=%b size=%0d src=%b px_wr=%b rd0=%b want 1/1/0/0/0/0",
                     bus.busy, bus.out_hdr_wr, bus.out_size, bus.out_src, bus.out_px_wr, bus.rd0);
        end
        @(posedge clk);
        #1;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.size0 = 6'd2;
        bus.size1 = 6'd2;
        #1;
        tests++;
        if ({bus.busy, bus.out_hdr_wr, bus.out_px_wr, bus.rd0} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL zero_return_idle got=%b want=0000",
                     {bus.busy, bus.out_hdr_wr, bus.out_px_wr, bus.rd0});
        end
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tests++;
        if ({bus.out_hdr_wr, bus.grant, bus.out_src, bus.out_size} !== {1'b1, 1'b1, 1'b1, 6'd2}) begin
            fails++;
            $display("[TB] FAIL zero_next_tie hdr_wr=%b grant=%b src=%b size=%0d want 1/1/1/2",
                     bus.out_hdr_wr, bus.grant, bus.out_src, bus.out_size);
        end
    endtask

    task automatic test_clamp();
        int         pix  = 0;
        bit         seen = 1'b0;
        logic [7:0] e0   = 8'd10;
        do_reset();
        bus.req0  = 1'b1;
        bus.size0 = 6'd40;
        for (int c = 0; c < 45; c++) begin
            #1;
            if (bus.out_hdr_wr) begin
                tests++;
                if (bus.out_size !== 6'd32) begin
                    fails++;
                    $display("[TB] FAIL clamp_header got=%0d want=32", bus.out_size);
                end
            end
            if (bus.out_px_wr) begin
                if (bus.out_px !== e0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL clamp_pixel n=%0d got=%0d want=%0d", pix, bus.out_px, e0);
                end
                e0 = e0 + 8'd1;
                pix++;
            end
            if (bus.busy) seen = 1'b1;
            if (seen && !bus.busy) break;
            @(posedge clk);
            #1;
            if (c == 0) bus.req0 = 1'b0;
        end
        tests++;
        if (pix != 32 || !seen || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL clamp_len got=%0d busy=%b want=32 busy=0", pix, bus.busy);
        end
    endtask

    task automatic test_request_drop();
        int         pix  = 0;
        bit         seen = 1'b0;
        logic [7:0] e0   = 8'd10;
        do_reset();
        bus.req0  = 1'b1;
        bus.size0 = 6'd6;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (bus.out_px_wr) begin
                tests++;
                if (bus.out_px !== e0 || bus.rd0 !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL drop_pixel n=%0d got=%0d rd0=%b want=%0d rd0=1",
                             pix, bus.out_px, bus.rd0, e0);
                end
                e0 = e0 + 8'd1;
                pix++;
            end
            if (bus.busy) seen = 1'b1;
            if (seen && !bus.busy) break;
            @(posedge clk);
            #1;
            if (pix >= 1) bus.req0 = 1'b0;
        end
        tests++;
        if (pix != 6 || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL drop_len got=%0d busy=%b want=6 busy=0", pix, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_final_beat_full();
        test_zero_size();
        test_clamp();
        test_request_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=bench complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
